// File: rtl/trap_controller_pkg.sv
// trap_controller_pkg: shared trap/CSR definitions (CSR addresses, interrupt cause, trap FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trap_controller_pkg;

  // Machine-mode CSR addresses owned by the trap controller.
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // mcause for a machine external interrupt (interrupt flag + code 11).
  localparam logic [31:0] MCAUSE_EXT_IRQ = 32'h8000_000B;

  typedef enum logic [1:0] {
    TRAP_IDLE   = 2'd0,
    TRAP_FLUSH  = 2'd1,
    TRAP_COMMIT = 2'd2
  } trap_state_e;

  // mstatus view: MPP fixed at M-mode, only MIE/MPIE live.
  function automatic logic [31:0] mstatus_view(input logic mie, input logic mpie);
    logic [31:0] v;
    v     = 32'h0000_1800;
    v[3]  = mie;
    v[7]  = mpie;
    return v;
  endfunction

endpackage

// File: rtl/trap_controller_if.sv
// trap_controller_if: groups the exception-unit, pipeline, fetch and CSR signals of the trap controller.
// Latency: n/a (wiring only). master = surrounding core, slave = trap_controller.
// Backpressure: i_err_pending held by master until o_err_handled; FLUSH waits on i_flush_ack.
// Config: TRAP_IRQ_EN adds i_ext_irq / i_irq_pc.
interface trap_controller_if;
  logic        i_err_pending;
  logic [31:0] i_err_pc;
  logic [31:0] i_err_cause;
  logic        o_err_handled;
  logic        o_flush;
  logic        i_flush_ack;
  logic        i_mret;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        i_csr_we;
  logic [11:0] i_csr_addr;
  logic [31:0] i_csr_wdata;
  logic [31:0] o_csr_rdata;
`ifdef TRAP_IRQ_EN
  logic        i_ext_irq;
  logic [31:0] i_irq_pc;
`endif

  modport master (
    output i_err_pending, i_err_pc, i_err_cause, i_flush_ack, i_mret,
           i_csr_we, i_csr_addr, i_csr_wdata,
`ifdef TRAP_IRQ_EN
           i_ext_irq, i_irq_pc,
`endif
    input  o_err_handled, o_flush, o_redirect_valid, o_redirect_pc, o_csr_rdata
  );

  modport slave (
    input  i_err_pending, i_err_pc, i_err_cause, i_flush_ack, i_mret,
           i_csr_we, i_csr_addr, i_csr_wdata,
`ifdef TRAP_IRQ_EN
           i_ext_irq, i_irq_pc,
`endif
    output o_err_handled, o_flush, o_redirect_valid, o_redirect_pc, o_csr_rdata
  );
endinterface

// File: rtl/trap_csr_regs.sv
// trap_csr_regs: mstatus/mtvec/mepc/mcause(/mie) storage, write masking and combinational read mux.
// Latency: writes/commit/mret update on the clock edge; reads are combinational (pre-edge values).
// Backpressure: none; the caller gates csr_we to cycles where writes are legal.
// Ports: clk, rst (async high), csr_we/addr/wdata/rdata, commit + commit_pc/cause, mret, mtvec/mepc out.
// Config: TRAP_IRQ_EN adds mie.MEIE storage, mip.MEIP mirror, ext_irq in, mie_en/meie out.
module trap_csr_regs
  import trap_controller_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic        commit,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_cause,
  input  logic        mret,
`ifdef TRAP_IRQ_EN
  input  logic        ext_irq,
  output logic        mie_en,
  output logic        meie,
`endif
  output logic [31:0] mtvec,
  output logic [31:0] mepc
);
  logic [31:0] mtvec_q, mepc_q, mcause_q;
  logic        mie_q, mpie_q;
`ifdef TRAP_IRQ_EN
  logic        meie_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtvec_q  <= MTVEC_RESET & ~32'h3;
      mepc_q   <= '0;
      mcause_q <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
`ifdef TRAP_IRQ_EN
      meie_q   <= 1'b0;
`endif
    end else if (commit) begin
      mepc_q   <= commit_pc & ~32'h3;
      mcause_q <= commit_cause;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else begin
      // mret owns mstatus this cycle; writes to other CSRs still land.
      if (mret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (csr_we && csr_addr == CSR_MSTATUS) begin
        mie_q  <= csr_wdata[3];
        mpie_q <= csr_wdata[7];
      end
      if (csr_we) begin
        case (csr_addr)
          CSR_MTVEC:  mtvec_q  <= csr_wdata & ~32'h3;
          CSR_MEPC:   mepc_q   <= csr_wdata & ~32'h3;
          CSR_MCAUSE: mcause_q <= csr_wdata;
`ifdef TRAP_IRQ_EN
          CSR_MIE:    meie_q   <= csr_wdata[11];
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = mstatus_view(mie_q, mpie_q);
      CSR_MTVEC:   csr_rdata = mtvec_q;
      CSR_MEPC:    csr_rdata = mepc_q;
      CSR_MCAUSE:  csr_rdata = mcause_q;
`ifdef TRAP_IRQ_EN
      CSR_MIE:     csr_rdata[11] = meie_q;
      CSR_MIP:     csr_rdata[11] = ext_irq;
`endif
      default:     csr_rdata = '0;
    endcase
  end

  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;
`ifdef TRAP_IRQ_EN
  assign mie_en = mie_q;
  assign meie   = meie_q;
`endif

endmodule

// File: rtl/trap_controller.sv
// trap_controller: M-mode trap controller; takes a pending trap, flushes, commits trap CSRs, redirects to mtvec; executes mret.
// Latency: trap sampled at edge N -> o_flush from N+1; COMMIT the cycle after i_flush_ack; mret redirect same cycle.
// Backpressure: stays in FLUSH until i_flush_ack; upstream holds i_err_pending until o_err_handled.
// Ports: i_clk, i_rst (async active-high), bus (trap_controller_if.slave).
// Config: TRAP_IRQ_EN adds external-interrupt entry (mie/mip CSRs, no o_err_handled on irq commits).
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic             i_clk,
  input  logic             i_rst,
  trap_controller_if.slave bus
);
  trap_state_e state_q, state_d;
  logic [31:0] trap_pc_q, trap_cause_q;
  logic        trap_irq_q;
  logic        in_idle, in_commit;
  logic        take_err, take_irq, take_mret;
  logic [31:0] mtvec, mepc;

  assign in_idle   = (state_q == TRAP_IDLE);
  assign in_commit = (state_q == TRAP_COMMIT);
  // A pending trap kills a same-cycle mret: the flush removes it.
  assign take_err  = in_idle && bus.i_err_pending;
  assign take_mret = in_idle && !bus.i_err_pending && bus.i_mret;

`ifdef TRAP_IRQ_EN
  logic mie_en, meie;
  assign take_irq = in_idle && !bus.i_err_pending && !bus.i_mret
                    && bus.i_ext_irq && mie_en && meie;
`else
  assign take_irq = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= TRAP_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      trap_pc_q    <= '0;
      trap_cause_q <= '0;
      trap_irq_q   <= 1'b0;
    end else if (take_err) begin
      trap_pc_q    <= bus.i_err_pc;
      trap_cause_q <= bus.i_err_cause;
      trap_irq_q   <= 1'b0;
    end else if (take_irq) begin
`ifdef TRAP_IRQ_EN
      trap_pc_q    <= bus.i_irq_pc;
`endif
      trap_cause_q <= MCAUSE_EXT_IRQ;
      trap_irq_q   <= 1'b1;
    end
  end

  // Outputs decode registered state only; mret redirect is the one IDLE exception.
  always_comb begin
    state_d              = state_q;
    bus.o_flush          = 1'b0;
    bus.o_err_handled    = 1'b0;
    bus.o_redirect_valid = 1'b0;
    bus.o_redirect_pc    = '0;
    case (state_q)
      TRAP_IDLE: begin
        if (take_err || take_irq) state_d = TRAP_FLUSH;
        if (take_mret) begin
          bus.o_redirect_valid = 1'b1;
          bus.o_redirect_pc    = mepc;
        end
      end
      TRAP_FLUSH: begin
        bus.o_flush = 1'b1;
        if (bus.i_flush_ack) state_d = TRAP_COMMIT;
      end
      TRAP_COMMIT: begin
        bus.o_err_handled    = !trap_irq_q;
        bus.o_redirect_valid = 1'b1;
        bus.o_redirect_pc    = {mtvec[31:2], 2'b00};
        state_d              = TRAP_IDLE;
      end
      default: state_d = TRAP_IDLE;
    endcase
  end

  trap_csr_regs #(.MTVEC_RESET(MTVEC_RESET)) u_csr (
    .clk          (i_clk),
    .rst          (i_rst),
    .csr_we       (bus.i_csr_we && in_idle),
    .csr_addr     (bus.i_csr_addr),
    .csr_wdata    (bus.i_csr_wdata),
    .csr_rdata    (bus.o_csr_rdata),
    .commit       (in_commit),
    .commit_pc    (trap_pc_q),
    .commit_cause (trap_cause_q),
    .mret         (take_mret),
`ifdef TRAP_IRQ_EN
    .ext_irq      (bus.i_ext_irq),
    .mie_en       (mie_en),
    .meie         (meie),
`endif
    .mtvec        (mtvec),
    .mepc         (mepc)
  );

endmodule
